// File: rtl/data_mem_responder_pkg.sv
// ---- mem_pkg : shared types and default widths for data_mem_responder (rev 1.0) ----
`default_nettype none

package mem_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ---- data_mem_responder_if : CPU data-memory strobe/response bundle (rev 1.0) ----
`default_nettype none

interface data_mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] data_out;
  logic              ready;
  logic              busy;
  logic              error;

  modport master (
    output address, data_in, mem_read, mem_write,
    input  data_out, ready, busy, error
  );

  modport slave (
    input  address, data_in, mem_read, mem_write,
    output data_out, ready, busy, error
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_responder_mem_array.sv
// ---- mem_array : synchronous-write, registered-read storage (rev 1.0) ----
`default_nettype none

module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              we,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] rdata
);

  // Storage deliberately has no reset so contents survive a reset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ---- data_mem_responder : wait-state handshaked memory target (rev 1.0) ----
`default_nettype none

module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input wire logic            clk,
  input wire logic            reset,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic              acc_en;
  op_e               acc_op;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = 1'b0;
    acc_en     = 1'b0;
    acc_op     = op_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_read ^ bus.mem_write) begin
          op_d       = bus.mem_write ? OP_WRITE : OP_READ;
          addr_d     = bus.address;
          wdata_d    = bus.data_in;
          wait_cnt_d = WAIT_CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the access happens on the sampling edge itself.
            state_d   = RESP;
            acc_en    = 1'b1;
            acc_op    = op_d;
            acc_addr  = bus.address;
            acc_wdata = bus.data_in;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.mem_read && bus.mem_write) begin
          error_d = 1'b1;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Reset must block a write that would otherwise land on the same edge.
  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (reset),
    .we    (acc_en && (acc_op == OP_WRITE) && !reset),
    .re    (acc_en && (acc_op == OP_READ)),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (bus.data_out)
  );

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ---- tb_data_mem_responder : directed scoreboard bench, WAIT_CYCLES = 2 and 0 (rev 1.0) ----
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  logic use0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if2 ();
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if0 ();

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  wire       ready_w = use0 ? if0.ready : if2.ready;
  wire       busy_w  = use0 ? if0.busy  : if2.busy;
  wire       error_w = use0 ? if0.error : if2.error;
  wire [7:0] dout_w  = use0 ? if0.data_out : if2.data_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if2.address = a;
    if2.data_in = d;
    if0.address = a;
    if0.data_in = d;
    if (use0) begin
      if0.mem_read  = rd;
      if0.mem_write = wr;
    end else begin
      if2.mem_read  = rd;
      if2.mem_write = wr;
    end
  endtask

  // One strobe cycle, then wait (bounded) for ready; checks latency, busy width, read data, return to idle.
  task automatic xact(input string tag, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input int lat_exp);
    int   cyc;
    int   busy_n;
    logic got;
    logic [7:0] exp_d;
    if (!wr) sb.push_back(d);
    drive(!wr, wr, a, wr ? d : 8'h00);
    cyc    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (cyc == 0) drive(1'b0, 1'b0, a, 8'h00);
      cyc++;
      if (busy_w) busy_n++;
      if (ready_w) got = 1'b1;
    end
    check($sformatf("%s_lat", tag), got ? cyc : 0, lat_exp);
    check($sformatf("%s_busy", tag), busy_n, lat_exp);
    if (!wr) begin
      exp_d = sb.pop_front();
      check($sformatf("%s_data", tag), dout_w, exp_d);
    end
    @(negedge clk);
    check($sformatf("%s_idle", tag), {busy_w, ready_w}, 2'b00);
  endtask

  initial begin
    int pulses;
    use0  = 1'b0;
    reset = 1'b1;
    if2.mem_read = 1'b0; if2.mem_write = 1'b0; if2.address = '0; if2.data_in = '0;
    if0.mem_read = 1'b0; if0.mem_write = 1'b0; if0.address = '0; if0.data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_dout",  if2.data_out, 8'h00);
    check("rst_ready", if2.ready, 1'b0);
    check("rst_busy",  if2.busy, 1'b0);
    check("rst_error", if2.error, 1'b0);
    check("rst0_ctl",  {if0.ready, if0.busy, if0.error}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    xact("wr10", 1'b1, 8'h10, 8'h3C, 3);
    xact("rd10", 1'b0, 8'h10, 8'h3C, 3);

    // Conflicting strobes.
    drive(1'b1, 1'b1, 8'h10, 8'h55);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    check("err_pulse", error_w, 1'b1);
    check("err_busy",  busy_w, 1'b0);
    @(negedge clk);
    check("err_clear", {error_w, busy_w, ready_w}, 3'b000);
    xact("err_rd10", 1'b0, 8'h10, 8'h3C, 3);

    // Write pulsed during WAIT of a read is ignored.
    sb.push_back(8'h3C);
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("ign_busy", busy_w, 1'b1);
    drive(1'b0, 1'b1, 8'h10, 8'hFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    check("ign_noready", ready_w, 1'b0);
    @(negedge clk);
    check("ign_ready", ready_w, 1'b1);
    check("ign_data", dout_w, sb.pop_front());
    @(negedge clk);
    check("ign_idle", {busy_w, ready_w}, 2'b00);
    xact("ign_rd10", 1'b0, 8'h10, 8'h3C, 3);

    // Reset during WAIT aborts a write.
    drive(1'b0, 1'b1, 8'h05, 8'hAA);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h05, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctl",  {busy_w, ready_w}, 2'b00);
    check("abort_dout", dout_w, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", ready_w, 1'b0);
    end
    xact("abort_rd05", 1'b0, 8'h05, 8'h00, 3);

    // Address extremes.
    xact("wrFF", 1'b1, 8'hFF, 8'h11, 3);
    xact("wr00", 1'b1, 8'h00, 8'h22, 3);
    xact("rdFF", 1'b0, 8'hFF, 8'h11, 3);
    xact("rd00", 1'b0, 8'h00, 8'h22, 3);

    // Held read gives back-to-back transactions every 4 cycles.
    repeat (3) sb.push_back(8'h3C);
    pulses = 0;
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 12) drive(1'b0, 1'b0, 8'h10, 8'h00);
      if (ready_w) begin
        pulses++;
        check("hold_pos", i, 4 * pulses - 1);
        if (sb.size() > 0) check("hold_data", dout_w, sb.pop_front());
      end
    end
    check("hold_pulses", pulses, 3);
    sb.delete();
    @(negedge clk);
    check("hold_idle", {busy_w, ready_w}, 2'b00);

    // Zero-wait instance.
    use0 = 1'b1;
    xact("z_wrFF", 1'b1, 8'hFF, 8'h11, 1);
    xact("z_wr00", 1'b1, 8'h00, 8'h22, 1);
    xact("z_rdFF", 1'b0, 8'hFF, 8'h11, 1);
    xact("z_rd00", 1'b0, 8'h00, 8'h22, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
